// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch front end with a decoupling queue. Issues one outstanding
// fetch at a time, predecodes RV32IC instruction size, statically predicts the
// next PC and buffers fetched instructions for decode. A redirect flushes the
// whole front end and restarts fetch at redirect_pc.
//
// Parameters:
//   XLEN      address / PC width
//   FQ_DEPTH  queue entries (power of two, >= 2)
//   RESET_PC  first PC fetched after reset
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mem_req, mem_addr, mem_ready     fetch request channel (registered outputs)
//   mem_rvalid, mem_rdata            fetch response channel
//   redirect, redirect_pc            flush and restart request
//   out_valid, out_ready             queue head handshake towards decode
//   out_instr, out_pc, out_pred_pc,
//   out_compressed                   queue head contents (registered)
//   jalr_wait                        fetch blocked on an unresolved indirect jump
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     FQ_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pred_pc,
    output logic            out_compressed,
    output logic            jalr_wait
);

    localparam int unsigned    AW      = $clog2(FQ_DEPTH);
    localparam int unsigned    PW      = AW + 1;
    localparam logic [PW-1:0]  DEPTH_P = PW'(FQ_DEPTH);
    localparam logic [PW-1:0]  PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] PC_TWO  = {{(XLEN-3){1'b0}}, 3'd2};
    localparam logic [XLEN-1:0] PC_FOUR = {{(XLEN-3){1'b0}}, 3'd4};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    // Static next-PC prediction: direct jumps taken, backward branches taken.
    function automatic logic [XLEN-1:0] predict_next(input logic [31:0] ins,
                                                     input logic comp,
                                                     input logic [XLEN-1:0] pc);
        logic [XLEN-1:0] seq_v;
        logic [XLEN-1:0] res_v;
        seq_v = comp ? (pc + PC_TWO) : (pc + PC_FOUR);
        res_v = seq_v;
        if (comp) begin
            if ((ins[1:0] == 2'b01) && ((ins[15:13] == 3'b101) || (ins[15:13] == 3'b001))) begin
                res_v = pc + {{(XLEN-12){ins[12]}}, ins[12], ins[8], ins[10:9], ins[6],
                              ins[7], ins[2], ins[11], ins[5:3], 1'b0};
            end else if ((ins[1:0] == 2'b01) && (ins[15:14] == 2'b11) && ins[12]) begin
                res_v = pc + {{(XLEN-9){ins[12]}}, ins[12], ins[6:5], ins[2],
                              ins[11:10], ins[4:3], 1'b0};
            end else begin
                res_v = seq_v;
            end
        end else begin
            case (ins[6:0])
                7'b1101111: res_v = pc + {{(XLEN-21){ins[31]}}, ins[31], ins[19:12],
                                          ins[20], ins[30:21], 1'b0};
                7'b1100011: res_v = ins[31] ? (pc + {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                                                     ins[30:25], ins[11:8], 1'b0})
                                            : seq_v;
                default:    res_v = seq_v;
            endcase
        end
        return res_v;
    endfunction

    // JALR, C.JR and C.JALR: target unknown until resolved downstream.
    function automatic logic is_indirect(input logic [31:0] ins, input logic comp);
        logic r_v;
        if (comp) begin
            r_v = (ins[1:0] == 2'b10) && (ins[15:13] == 3'b100) &&
                  (ins[11:7] != 5'd0) && (ins[6:2] == 5'd0);
        end else begin
            r_v = (ins[6:0] == 7'b1100111);
        end
        return r_v;
    endfunction

    state_t          state_r, state_s;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_s;
    logic [PW-1:0]   head_r, tail_r, head_s, tail_s, count_s;
    logic            outstanding_r, outstanding_s;
    logic            discard_r, discard_s;
    logic            mem_req_r;
    logic [XLEN-1:0] mem_addr_r;
    logic            out_valid_r, out_compressed_r, jalr_wait_r;
    logic [31:0]     out_instr_r;
    logic [XLEN-1:0] out_pc_r, out_pred_pc_r;

    logic [31:0]     q_instr_r   [FQ_DEPTH];
    logic [XLEN-1:0] q_pc_r      [FQ_DEPTH];
    logic [XLEN-1:0] q_pred_r    [FQ_DEPTH];
    logic            q_comp_r    [FQ_DEPTH];

    logic            accept_s, resp_s, push_s, pop_s;
    logic            comp_s, indirect_s;
    logic [31:0]     instr_s;
    logic [XLEN-1:0] pred_s;
    logic            req_s, valid_s, comp_next_s;
    logic [31:0]     instr_next_s;
    logic [XLEN-1:0] pc_next_s, pred_next_s;

    assign accept_s = mem_req_r && mem_ready;
    assign resp_s   = mem_rvalid && outstanding_r;
    // A response is only kept when it belongs to the live fetch stream.
    assign push_s   = resp_s && !discard_r && !redirect && (state_r == ST_WAIT);
    assign pop_s    = out_valid_r && out_ready && !redirect;

    // Predecode of the incoming response word.
    always_comb begin
        comp_s     = (mem_rdata[1:0] != 2'b11);
        instr_s    = comp_s ? {16'h0000, mem_rdata[15:0]} : mem_rdata;
        pred_s     = predict_next(instr_s, comp_s, fetch_pc_r);
        indirect_s = is_indirect(instr_s, comp_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; redirect overrides everything including BLOCK.
    always_comb begin
        state_s = state_r;
        if (redirect) begin
            state_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: state_s = accept_s ? ST_WAIT : ST_FETCH;
                ST_WAIT:  begin
                    if (push_s) begin
                        state_s = indirect_s ? ST_BLOCK : ST_FETCH;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_BLOCK: state_s = ST_BLOCK;
                default:  state_s = ST_FETCH;
            endcase
        end
    end

    // Pointer, PC and outstanding/discard bookkeeping for the next cycle.
    always_comb begin
        outstanding_s = outstanding_r;
        if (accept_s) begin
            outstanding_s = 1'b1;
        end else if (resp_s) begin
            outstanding_s = 1'b0;
        end else begin
            outstanding_s = outstanding_r;
        end
        // Anything still in flight after a redirect belongs to the old stream.
        if (redirect) begin
            discard_s = outstanding_s;
        end else if (resp_s) begin
            discard_s = 1'b0;
        end else begin
            discard_s = discard_r;
        end
        if (redirect) begin
            fetch_pc_s = redirect_pc;
            head_s     = tail_r;
            tail_s     = tail_r;
        end else begin
            fetch_pc_s = push_s ? pred_s : fetch_pc_r;
            head_s     = pop_s ? (head_r + PTR_ONE) : head_r;
            tail_s     = push_s ? (tail_r + PTR_ONE) : tail_r;
        end
        count_s = tail_s - head_s;
    end

    // Output logic: next values of the registered request and head outputs.
    always_comb begin
        req_s   = (state_s == ST_FETCH) && !outstanding_s && (count_s < DEPTH_P);
        valid_s = (count_s != {PW{1'b0}});
        if (!valid_s) begin
            instr_next_s = 32'h0000_0000;
            pc_next_s    = {XLEN{1'b0}};
            pred_next_s  = {XLEN{1'b0}};
            comp_next_s  = 1'b0;
        end else if (push_s && (head_s == tail_r)) begin
            // The new head is the entry being written at this edge.
            instr_next_s = instr_s;
            pc_next_s    = fetch_pc_r;
            pred_next_s  = pred_s;
            comp_next_s  = comp_s;
        end else begin
            instr_next_s = q_instr_r[head_s[AW-1:0]];
            pc_next_s    = q_pc_r[head_s[AW-1:0]];
            pred_next_s  = q_pred_r[head_s[AW-1:0]];
            comp_next_s  = q_comp_r[head_s[AW-1:0]];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r       <= RESET_PC;
            head_r           <= {PW{1'b0}};
            tail_r           <= {PW{1'b0}};
            outstanding_r    <= 1'b0;
            discard_r        <= 1'b0;
            mem_req_r        <= 1'b0;
            mem_addr_r       <= {XLEN{1'b0}};
            out_valid_r      <= 1'b0;
            out_instr_r      <= 32'h0000_0000;
            out_pc_r         <= {XLEN{1'b0}};
            out_pred_pc_r    <= {XLEN{1'b0}};
            out_compressed_r <= 1'b0;
            jalr_wait_r      <= 1'b0;
        end else begin
            fetch_pc_r       <= fetch_pc_s;
            head_r           <= head_s;
            tail_r           <= tail_s;
            outstanding_r    <= outstanding_s;
            discard_r        <= discard_s;
            mem_req_r        <= req_s;
            mem_addr_r       <= req_s ? fetch_pc_s : mem_addr_r;
            out_valid_r      <= valid_s;
            out_instr_r      <= instr_next_s;
            out_pc_r         <= pc_next_s;
            out_pred_pc_r    <= pred_next_s;
            out_compressed_r <= comp_next_s;
            jalr_wait_r      <= (state_s == ST_BLOCK);
        end
    end

    // Queue storage; a slot is always free because it was reserved at request.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_instr_r[tail_r[AW-1:0]] <= instr_s;
            q_pc_r[tail_r[AW-1:0]]    <= fetch_pc_r;
            q_pred_r[tail_r[AW-1:0]]  <= pred_s;
            q_comp_r[tail_r[AW-1:0]]  <= comp_s;
        end
    end

    assign mem_req        = mem_req_r;
    assign mem_addr       = mem_addr_r;
    assign out_valid      = out_valid_r;
    assign out_instr      = out_instr_r;
    assign out_pc         = out_pc_r;
    assign out_pred_pc    = out_pred_pc_r;
    assign out_compressed = out_compressed_r;
    assign jalr_wait      = jalr_wait_r;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_queue_unit. A memory responder serves fetches from a
// small program table; stimulus pushes hand-computed expected queue entries
// into a scoreboard and a separate monitor compares every popped entry.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pred_pc;
    logic        out_compressed;
    logic        jalr_wait;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        comp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          mem_lat = 1;

    fetch_queue_unit #(
        .XLEN(32), .FQ_DEPTH(8), .RESET_PC(32'h0000_0100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pred_pc(out_pred_pc),
        .out_compressed(out_compressed), .jalr_wait(jalr_wait)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h200: return 32'hABCD_0001;  // c.nop, junk upper half
            32'h300: return 32'hFF9F_F06F;  // jal x0,-8
            32'h400: return 32'h0000_0863;  // beq x0,x0,+16
            32'h404: return 32'hFE00_0EE3;  // beq x0,x0,-4
            32'h500: return 32'h1234_BFF5;  // c.j -4, junk upper half
            32'h600: return 32'h0000_8067;  // jalr x0,0(x1)
            default: return 32'h0000_0013;  // nop
        endcase
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pred, input logic comp);
        exp_t e;
        e.instr = instr; e.pc = pc; e.pred = pred; e.comp = comp;
        exp_q.push_back(e);
    endtask

    // Assert redirect for one cycle; expectations must be queued by caller after this starts.
    task automatic start_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = pc;
        req_log.delete();
    endtask

    task automatic end_redirect();
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_drain_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Memory responder: one outstanding request, fixed latency.
    initial begin
        logic [31:0] a;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_ready) begin
                a = mem_addr;
                if (!redirect) req_log.push_back(a);
                @(posedge clk);
                repeat (mem_lat - 1) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(a);
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
    end

    // Scoreboard monitor: compares every consumed head entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !redirect && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_instr, out_pc, out_pred_pc, out_compressed} !== e) begin
                    n_fail++;
                    $display("FAIL entry@%h: got instr=%h pc=%h pred=%h c=%b expected instr=%h pc=%h pred=%h c=%b",
                             e.pc, out_instr, out_pc, out_pred_pc, out_compressed,
                             e.instr, e.pc, e.pred, e.comp);
                end
            end
        end
    end

    initial begin
        bit bad;
        rst_n       = 1'b0;
        mem_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_jalr_wait", {31'd0, jalr_wait}, 32'd0);
        check("rst_out_instr", out_instr,          32'd0);

        // Straight-line nops from RESET_PC.
        expect_entry(32'h100, 32'h13, 32'h104, 1'b0);
        expect_entry(32'h104, 32'h13, 32'h108, 1'b0);
        expect_entry(32'h108, 32'h13, 32'h10C, 1'b0);
        rst_n = 1'b1;
        drain("reset_seq", 60);
        check("reset_addr0", log_at(0), 32'h100);
        check("reset_addr1", log_at(1), 32'h104);
        check("reset_addr2", log_at(2), 32'h108);

        // Compressed nop: zero-extended, next fetch at +2.
        start_redirect(32'h200);
        expect_entry(32'h200, 32'h0000_0001, 32'h202, 1'b1);
        expect_entry(32'h202, 32'h13, 32'h206, 1'b0);
        end_redirect();
        drain("cnop", 60);
        check("cnop_next_addr", log_at(1), 32'h202);

        // Backward JAL taken.
        start_redirect(32'h300);
        expect_entry(32'h300, 32'hFF9F_F06F, 32'h2F8, 1'b0);
        expect_entry(32'h2F8, 32'h13, 32'h2FC, 1'b0);
        end_redirect();
        drain("jal", 60);
        check("jal_next_addr", log_at(1), 32'h2F8);

        // Forward branch not taken, backward branch taken.
        start_redirect(32'h400);
        expect_entry(32'h400, 32'h0000_0863, 32'h404, 1'b0);
        expect_entry(32'h404, 32'hFE00_0EE3, 32'h400, 1'b0);
        expect_entry(32'h400, 32'h0000_0863, 32'h404, 1'b0);
        end_redirect();
        drain("branch", 60);

        // C.J backward.
        start_redirect(32'h500);
        expect_entry(32'h500, 32'h0000_BFF5, 32'h4FC, 1'b1);
        expect_entry(32'h4FC, 32'h13, 32'h500, 1'b0);
        end_redirect();
        drain("cj", 60);

        // Queue full: decode stalled, exactly FQ_DEPTH requests.
        start_redirect(32'hA00);
        out_ready = 1'b0;
        end_redirect();
        repeat (30) @(posedge clk);
        #1;
        check("full_req_count", req_log.size(), 32'd8);
        check("full_mem_req",   {31'd0, mem_req},   32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        expect_entry(32'hA00, 32'h13, 32'hA04, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pop_req_count", req_log.size(), 32'd9);
        check("pop_mem_req",   {31'd0, mem_req}, 32'd0);
        check("pop_consumed",  exp_q.size(),     32'd0);

        // JALR blocks fetch until redirect.
        start_redirect(32'h600);
        out_ready = 1'b1;
        expect_entry(32'h600, 32'h0000_8067, 32'h604, 1'b0);
        end_redirect();
        drain("jalr", 60);
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!jalr_wait || mem_req) bad = 1'b1;
        end
        check("jalr_block_20", {31'd0, bad}, 32'd0);
        check("jalr_one_req", req_log.size(), 32'd1);
        start_redirect(32'h800);
        expect_entry(32'h800, 32'h13, 32'h804, 1'b0);
        end_redirect();
        check("redir_mem_req",   {31'd0, mem_req},   32'd1);
        check("redir_mem_addr",  mem_addr,           32'h800);
        check("redir_jalr_wait", {31'd0, jalr_wait}, 32'd0);
        check("redir_out_valid", {31'd0, out_valid}, 32'd0);
        drain("after_jalr", 60);

        // Redirect while a slow fetch is outstanding: stale response dropped.
        mem_lat = 5;
        start_redirect(32'h700);
        end_redirect();
        begin
            int n;
            n = 0;
            while (req_log.size() == 0 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("stale_req_seen", req_log.size(), 32'd1);
        repeat (2) @(posedge clk);
        start_redirect(32'h900);
        expect_entry(32'h900, 32'h13, 32'h904, 1'b0);
        expect_entry(32'h904, 32'h13, 32'h908, 1'b0);
        end_redirect();
        check("stale_mem_req",   {31'd0, mem_req},   32'd0);
        check("stale_out_valid", {31'd0, out_valid}, 32'd0);
        drain("stale", 120);
        check("stale_first_addr", log_at(0), 32'h900);
        mem_lat = 1;

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
